fb_fetch_scheduler: RTL and testbench

FB_FETCH_SCHEDULER -- requirements
Module: fb_fetch_scheduler

---
 rtl/fb_fetch_scheduler.sv | 133 +++++++++++++
 tb/tb_fb_fetch_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fb_fetch_scheduler.sv
// Frame-buffer fetch scheduler: copies one image row into a ping-pong line buffer ahead
// of display, and arbitrates the single-port frame buffer between display fetch and writer.
module fb_fetch_scheduler #(
    parameter int unsigned VBP   = 33,
    parameter int unsigned ROWH  = 12,
    parameter int unsigned NROWS = 40,
    parameter int unsigned NCOLS = 256
) (
    input  logic        vgaclk,
    input  logic        rst,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        wr_req,
    input  logic [13:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [13:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        lb_we,
    output logic        lb_bank,
    output logic [7:0]  lb_addr,
    output logic [15:0] lb_wdata,
    output logic        disp_bank,
    output logic        overrun
);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e      state_q, state_d;
    logic [7:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic [7:0]  rd_col_q;
    logic        rd_valid_q;
    logic        disp_bank_q;
    logic        overrun_q;

    logic        trig;
    logic [5:0]  trig_row;
    logic        swap;
    logic        swap_bank;
    logic        fetch_rd;
    logic        wr_grant;
    logic        wr_in_range;

    // Fetch of row k starts one image row before row k is displayed.
    always_comb begin
        trig      = 1'b0;
        trig_row  = '0;
        swap      = 1'b0;
        swap_bank = 1'b0;
        if (hc == 10'd0) begin
            for (int k = 0; k < NROWS; k++) begin
                if (vc == 10'(VBP - ROWH + ROWH * k)) begin
                    trig     = 1'b1;
                    trig_row = 6'(k);
                end
                if (vc == 10'(VBP + ROWH * k)) begin
                    swap      = 1'b1;
                    swap_bank = k[0];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    state_d = StFetch;
                    col_d   = '0;
                    row_d   = trig_row;
                end
            end
            StFetch: begin
                col_d = col_q + 8'd1;
                if (col_q == 8'(NCOLS - 1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fetch_rd    = (state_q == StFetch);
        wr_in_range = 32'(wr_addr[13:8]) < NROWS;
        wr_grant    = wr_req && !rst && !trig && (state_q == StIdle || state_q == StDrain);
        wr_ack      = wr_grant;
        mem_en      = fetch_rd || (wr_grant && wr_in_range);
        mem_we      = !fetch_rd && wr_grant && wr_in_range;
        mem_addr    = fetch_rd ? {row_q, col_q} : wr_addr;
        mem_wdata   = wr_data;
        // Read data lands one cycle after its address, so the buffer write trails the read.
        lb_we       = rd_valid_q;
        lb_addr     = rd_col_q;
        lb_bank     = row_q[0];
        lb_wdata    = mem_rdata;
        disp_bank   = disp_bank_q;
        overrun     = overrun_q;
    end

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            rd_col_q    <= '0;
            rd_valid_q  <= 1'b0;
            disp_bank_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            rd_col_q   <= col_q;
            rd_valid_q <= fetch_rd;
            if (swap) begin
                disp_bank_q <= swap_bank;
            end
            if (trig && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_fetch_scheduler.sv
// Directed bench for fb_fetch_scheduler with a registered-read frame-buffer model.
module tb_fb_fetch_scheduler;

    logic        vgaclk = 1'b0;
    logic        rst;
    logic [9:0]  hc, vc;
    logic        wr_req;
    logic [13:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack, mem_en, mem_we;
    logic [13:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        lb_we, lb_bank, disp_bank, overrun;
    logic [7:0]  lb_addr;
    logic [15:0] lb_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    fb_fetch_scheduler dut (
        .vgaclk    (vgaclk),
        .rst       (rst),
        .hc        (hc),
        .vc        (vc),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .lb_we     (lb_we),
        .lb_bank   (lb_bank),
        .lb_addr   (lb_addr),
        .lb_wdata  (lb_wdata),
        .disp_bank (disp_bank),
        .overrun   (overrun)
    );

    always #20 vgaclk = ~vgaclk;

    function automatic logic [15:0] pat(input logic [13:0] a);
        return 16'hA5A5 ^ {2'b00, a};
    endfunction

    // Frame buffer: read data valid one cycle after the read request.
    always @(posedge vgaclk) begin
        if (mem_en && !mem_we) mem_rdata <= pat(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge vgaclk);
        #1;
    endtask

    initial begin
        rst = 1'b1; hc = 10'd1; vc = 10'd0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        step(); step();
        rst = 1'b0; #1;
        check("rst_wr_ack", 32'(wr_ack), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_lb_we", 32'(lb_we), 0);
        check("rst_disp_bank", 32'(disp_bank), 0);
        check("rst_overrun", 32'(overrun), 0);

        // Out-of-range write is acked but dropped
        wr_req = 1'b1; wr_addr = {6'd40, 8'd0}; #1;
        check("oor_ack", 32'(wr_ack), 1);
        check("oor_mem_en", 32'(mem_en), 0);
        step();

        // T-2 and T-1: writes granted in IDLE
        wr_addr = 14'h0105; wr_data = 16'hBEEF; #1;
        check("wr_ack_tm2", 32'(wr_ack), 1);
        check("wr_mem_en", 32'(mem_en), 1);
        check("wr_mem_we", 32'(mem_we), 1);
        check("wr_mem_addr", 32'(mem_addr), 32'h0105);
        check("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        step();
        wr_addr = 14'h0203; #1;
        check("wr_ack_tm1", 32'(wr_ack), 1);
        step();

        // T: trig for row 0 blocks the write
        hc = 10'd0; vc = 10'd21; #1;
        check("trig_no_ack", 32'(wr_ack), 0);
        check("trig_mem_en", 32'(mem_en), 0);
        step();
        hc = 10'd1;
        for (int c = 0; c < 256; c++) begin
            #1;
            check("f0_mem_en", 32'(mem_en), 1);
            check("f0_mem_we", 32'(mem_we), 0);
            check("f0_mem_addr", 32'(mem_addr), 32'(c));
            check("f0_no_ack", 32'(wr_ack), 0);
            if (c == 0) begin
                check("f0_lb_we0", 32'(lb_we), 0);
            end else begin
                check("f0_lb_we", 32'(lb_we), 1);
                check("f0_lb_addr", 32'(lb_addr), 32'(c - 1));
                check("f0_lb_bank", 32'(lb_bank), 0);
                check("f0_lb_wdata", 32'(lb_wdata), 32'(pat(14'(c - 1))));
            end
            step();
        end
        // T+257: DRAIN, last buffer write plus granted memory write
        #1;
        check("d0_lb_we", 32'(lb_we), 1);
        check("d0_lb_addr", 32'(lb_addr), 255);
        check("d0_lb_wdata", 32'(lb_wdata), 32'(pat(14'd255)));
        check("d0_wr_ack", 32'(wr_ack), 1);
        check("d0_mem_we", 32'(mem_we), 1);
        check("d0_mem_en", 32'(mem_en), 1);
        wr_req = 1'b0;
        step();
        #1;
        check("idle_lb_we", 32'(lb_we), 0);
        check("idle_mem_en", 32'(mem_en), 0);

        // Row 1 fetch into bank 1; extra trig at T+10 flags overrun
        hc = 10'd0; vc = 10'd33;
        step();
        hc = 10'd1; #1;
        check("swap_bank0", 32'(disp_bank), 0);
        for (int c = 0; c < 256; c++) begin
            if (c == 9) begin
                hc = 10'd0; vc = 10'd45;
            end else begin
                hc = 10'd1; vc = 10'd33;
            end
            #1;
            check("f1_mem_addr", 32'(mem_addr), 32'({6'd1, 8'(c)}));
            check("f1_mem_en", 32'(mem_en), 1);
            if (c == 1) begin
                check("f1_lb_bank", 32'(lb_bank), 1);
                check("f1_lb_addr", 32'(lb_addr), 0);
            end
            if (c == 10) begin
                check("ovr_set", 32'(overrun), 1);
                check("swap_bank1", 32'(disp_bank), 1);
            end
            step();
        end
        #1;
        check("f1_drain_lb_we", 32'(lb_we), 1);
        step();
        #1;
        check("ovr_sticky", 32'(overrun), 1);
        check("f1_idle_mem_en", 32'(mem_en), 0);

        // Row 3 fetch, reset at column 100
        hc = 10'd0; vc = 10'd57;
        step();
        hc = 10'd1;
        for (int c = 0; c <= 100; c++) begin
            if (c == 100) rst = 1'b1;
            #1;
            check("f3_mem_addr", 32'(mem_addr), 32'({6'd3, 8'(c)}));
            step();
        end
        rst = 1'b0; #1;
        check("abort_mem_en", 32'(mem_en), 0);
        check("abort_lb_we", 32'(lb_we), 0);
        check("abort_overrun", 32'(overrun), 0);
        check("abort_disp_bank", 32'(disp_bank), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_resume_mem_en", 32'(mem_en), 0);
            check("no_resume_lb_we", 32'(lb_we), 0);
        end

        // Reset wins over a simultaneous trig and write request
        rst = 1'b1; hc = 10'd0; vc = 10'd21; wr_req = 1'b1; wr_addr = 14'h0001; #1;
        check("rst_trig_ack", 32'(wr_ack), 0);
        step();
        rst = 1'b0; hc = 10'd1; wr_req = 1'b0; #1;
        check("rst_trig_mem_en", 32'(mem_en), 0);
        step();
        check("rst_trig_lb_we", 32'(lb_we), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
